// File: rtl/pu_io_arb.sv
// pu_io_arb: round-robin N-to-1 arbiter onto one pipelined SRAM port.
// Optional PU_IO_ARB_PRIO_EN: requester 0 gets strict priority.
module pu_io_arb #(
  parameter int NUM_REQ    = 8,
  parameter int ADDR_NBITS = 10,
  parameter int DATA_NBITS = 32,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            io_req,
  input  logic [NUM_REQ-1:0]            io_wr,
  input  logic [NUM_REQ*ADDR_NBITS-1:0] io_addr,
  input  logic [NUM_REQ*DATA_NBITS-1:0] io_wdata,
  output logic [NUM_REQ-1:0]            io_ack,
  output logic [NUM_REQ*DATA_NBITS-1:0] io_ack_data,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [ADDR_NBITS-1:0]         mem_addr,
  output logic [DATA_NBITS-1:0]         mem_wdata,
  input  logic [DATA_NBITS-1:0]         mem_rdata
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    pending;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    rr_elig;
  logic [NUM_REQ-1:0]    gnt_mask;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         rr_id;
  logic                  rr_vld;
  logic [IW-1:0]         gnt_id;
  logic                  gnt_vld;
  logic                  ptr_upd;
  logic                  sel_wr;
  logic [ADDR_NBITS-1:0] sel_addr;
  logic [DATA_NBITS-1:0] sel_wdata;

  logic [RD_LAT:0]       pv;
  logic [RD_LAT:0]       pw;
  logic [IW-1:0]         pid [RD_LAT+1];

  // Grant selection: first eligible after rr_ptr, optional prio on 0
  always_comb begin
    elig    = io_req & ~pending;
    rr_elig = elig;
    rr_vld  = 1'b0;
    rr_id   = '0;
`ifdef PU_IO_ARB_PRIO_EN
    rr_elig[0] = 1'b0;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!rr_vld && rr_elig[IW'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        rr_vld = 1'b1;
        rr_id  = IW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
    gnt_vld = rr_vld;
    gnt_id  = rr_id;
    ptr_upd = rr_vld;
`ifdef PU_IO_ARB_PRIO_EN
    if (elig[0]) begin
      gnt_vld = 1'b1;
      gnt_id  = '0;
      ptr_upd = 1'b0;
    end
`endif
  end

  // Mux the granted requester's command fields
  always_comb begin
    gnt_mask  = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IW'(i)) begin
        gnt_mask[i] = gnt_vld;
        sel_wr      = io_wr[i];
        sel_addr    = io_addr[i*ADDR_NBITS +: ADDR_NBITS];
        sel_wdata   = io_wdata[i*DATA_NBITS +: DATA_NBITS];
      end
    end
  end

  // Ack decode from the tail of the completion pipe
  always_comb begin
    io_ack      = '0;
    io_ack_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pv[RD_LAT] && pid[RD_LAT] == IW'(i)) begin
        io_ack[i] = 1'b1;
        if (!pw[RD_LAT]) begin
          io_ack_data[i*DATA_NBITS +: DATA_NBITS] = mem_rdata;
        end
      end
    end
  end

  // Pending flags, rr pointer and SRAM command register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      rr_ptr    <= IW'(NUM_REQ - 1);
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      pending <= (pending & ~io_ack) | gnt_mask;
      if (ptr_upd) begin
        rr_ptr <= gnt_id;
      end
      mem_rd <= gnt_vld & ~sel_wr;
      mem_wr <= gnt_vld & sel_wr;
      if (gnt_vld) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

  // Completion pipe: uniform latency for reads and writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      pw <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        pid[k] <= '0;
      end
    end else begin
      pv[0]  <= gnt_vld;
      pw[0]  <= sel_wr;
      pid[0] <= gnt_id;
      for (int k = 1; k <= RD_LAT; k++) begin
        pv[k]  <= pv[k-1];
        pw[k]  <= pw[k-1];
        pid[k] <= pid[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pu_io_arb.sv
// tb_pu_io_arb: queue-based arbiter model plus SRAM model,
// per-cycle compare and directed literal checks.
module tb_pu_io_arb;

  localparam int N  = 8;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    io_req = '0;
  logic [N-1:0]    io_wr = '0;
  logic [N*AW-1:0] io_addr = '0;
  logic [N*DW-1:0] io_wdata = '0;
  logic [N-1:0]    io_ack;
  logic [N*DW-1:0] io_ack_data;
  logic            mem_rd;
  logic            mem_wr;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  pu_io_arb #(
    .NUM_REQ(N), .ADDR_NBITS(AW), .DATA_NBITS(DW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .io_req(io_req), .io_wr(io_wr),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_ack_data(io_ack_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  // SRAM model with RL-cycle read latency
  logic [DW-1:0] sram [1024];
  logic [DW-1:0] rd_pipe [RL];
  assign mem_rdata = rd_pipe[RL-1];

  always @(posedge clk) begin
    for (int k = RL - 1; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
    rd_pipe[0] = mem_rd ? sram[mem_addr] : '0;
    if (mem_wr) sram[mem_addr] = mem_wdata;
  end

  // Behavioural arbiter model
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } ack_t;

  ack_t          q[$];
  logic [DW-1:0] mm [1024];
  logic [N-1:0]  m_pend = '0;
  int            m_rr = N - 1;
  int            cyc = 0;
  logic          e_rd = 1'b0;
  logic          e_wr = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;

  initial begin
    for (int a = 0; a < 1024; a++) begin
      sram[a] = 32'hA500_0000 | a;
      mm[a]   = 32'hA500_0000 | a;
    end
    sram[10'h12] = 32'hCAFE_0001;
    mm[10'h12]   = 32'hCAFE_0001;
    for (int k = 0; k < RL; k++) rd_pipe[k] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0]  el;
    int            g;
    int            c;
    logic [AW-1:0] a;
    ack_t          e;
    if (!rst_n) begin
      q.delete();
      m_pend  = '0;
      m_rr    = N - 1;
      e_rd    = 1'b0;
      e_wr    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
    end else begin
      el = io_req & ~m_pend;
      g  = -1;
`ifdef PU_IO_ARB_PRIO_EN
      if (el[0]) g = 0;
`endif
      for (int k = 1; k <= N; k++) begin
        c = (m_rr + k) % N;
        if (g < 0 && el[c]) g = c;
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        m_pend[q[0].id] = 1'b0;
        void'(q.pop_front());
      end
      e_rd = 1'b0;
      e_wr = 1'b0;
      if (g >= 0) begin
        a      = io_addr[g*AW +: AW];
        e_addr = a;
        e_rd   = !io_wr[g];
        e_wr   = io_wr[g];
        e_wdata = io_wdata[g*DW +: DW];
        e.due  = cyc + 1 + RL;
        e.id   = g;
        e.data = io_wr[g] ? 32'h0 : mm[a];
        if (io_wr[g]) mm[a] = io_wdata[g*DW +: DW];
        q.push_back(e);
        m_pend[g] = 1'b1;
`ifdef PU_IO_ARB_PRIO_EN
        if (g != 0) m_rr = g;
`else
        m_rr = g;
`endif
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [N-1:0]    ea;
    logic [N*DW-1:0] ed;
    ea = '0;
    ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ea[q[0].id] = 1'b1;
      ed[q[0].id*DW +: DW] = q[0].data;
    end
    chk("ack", io_ack, ea);
    chk("ack_data", io_ack_data, ed);
    chk("mem_rd", mem_rd, e_rd);
    chk("mem_wr", mem_wr, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
  end

  task automatic rst_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    io_req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(int id, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!io_ack[id] && n < 20);
    if (!io_ack[id]) begin
      errors++;
      $display("FAIL wait_ack id=%0d timeout after %0d cycles", id, n);
    end
  endtask

  task automatic set_req(int i, logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    io_req[i] = 1'b1;
    io_wr[i]  = wr;
    io_addr[i*AW +: AW] = a;
    io_wdata[i*DW +: DW] = d;
  endtask

  int n;
  int seq5 [8];
  logic [N*DW-1:0] t1d;

  initial begin
`ifdef PU_IO_ARB_PRIO_EN
    seq5 = '{0, 1, 2, 3, 0, 4, 1, 2};
`else
    seq5 = '{0, 1, 2, 3, 4, 0, 1, 2};
`endif
    repeat (3) @(negedge clk);
    chk("rst_ack", io_ack, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single read by requester 3
    set_req(3, 1'b0, 10'h12, 32'h0);
    @(negedge clk);
    chk("t1_rd", mem_rd, 1);
    chk("t1_addr", mem_addr, 10'h12);
    @(negedge clk);
    chk("t1_noack", io_ack, 0);
    @(negedge clk);
    t1d = '0;
    t1d[3*DW +: DW] = 32'hCAFE_0001;
    chk("t1_ack", io_ack, 8'h08);
    chk("t1_data", io_ack_data, t1d);
    io_req = '0;
    repeat (2) @(negedge clk);

    // all eight requesters, two full rounds
    rst_pulse();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 32'h0);
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      chk("t2_rd", mem_rd, 1);
      chk("t2_addr", mem_addr, k % N);
    end
    io_req = '0;
    repeat (6) @(negedge clk);

    // write then back-to-back read by requester 5
    set_req(5, 1'b1, 10'h3FF, 32'hDEAD_BEEF);
    wait_ack(5, n);
    chk("t3_wlat", n, 3);
    chk("t3_wdata0", io_ack_data, 0);
    io_wr[5] = 1'b0;
    wait_ack(5, n);
    chk("t3_rlat", n, 4);
    chk("t3_rdata", io_ack_data[5*DW +: DW], 32'hDEAD_BEEF);
    io_req = '0;
    repeat (3) @(negedge clk);

    // reset with reads in flight
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(i + 32), 32'h0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    io_req = '0;
    #1;
    chk("t4_ack", io_ack, 0);
    chk("t4_data", io_ack_data, 0);
    chk("t4_rd", mem_rd, 0);
    chk("t4_addr", mem_addr, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(2, 1'b0, 10'h12, 32'h0);
    wait_ack(2, n);
    chk("t4_lat", n, 3);
    chk("t4_rdata", io_ack_data[2*DW +: DW], 32'hCAFE_0001);
    io_req = '0;
    repeat (3) @(negedge clk);

    // five requesters held high: rotation vs priority
    rst_pulse();
    for (int i = 0; i < 5; i++) set_req(i, 1'b0, AW'(i), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_rd", mem_rd, 1);
      chk("t5_addr", mem_addr, seq5[k]);
    end
    io_req = '0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
